// File: rtl/lab3_keypad_pkg.sv
// lab3_keypad_pkg
//   Shared types and helpers for the lab3 keypad scanner.
//   scan_state_t : scanner FSM states
//   keymap()     : translates the driven column index and the one-hot
//                  row pattern into the hex code printed on the key cap
package lab3_keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } scan_state_t;

    // Each row holds the four key codes packed as nibbles, column 0 in the
    // low nibble, so the column index selects the nibble directly.
    function automatic logic [3:0] keymap(input logic [1:0] col_idx,
                                          input logic [3:0] row_onehot);
        logic [15:0] row_codes;
        case (row_onehot)
            4'b0001: row_codes = 16'hFB0A;
            4'b0010: row_codes = 16'hE987;
            4'b0100: row_codes = 16'hD654;
            4'b1000: row_codes = 16'hC321;
            default: row_codes = 16'h0000;
        endcase
        return row_codes[{col_idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/lab3_stable_counter.sv
// lab3_stable_counter
//   Counts consecutive stable cycles for the keypad debouncer.
//   Ports:
//     clk   in  system clock
//     reset in  asynchronous, active-low reset
//     clear in  zero the count (takes priority over inc)
//     inc   in  advance the count by one
//     done  out count has reached DEBOUNCE_CYC-1
module lab3_stable_counter #(
    parameter int DEBOUNCE_CYC = 400_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] count;

    // The count parks at its last value instead of wrapping, so a long
    // stable period can never roll over and look like a fresh start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !done) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CNT_LAST);

endmodule

// File: rtl/lab3_keypad_scanner.sv
// lab3_keypad_scanner
//   4x4 matrix keypad scanner: strobes the columns one-hot, samples the
//   synchronised rows, debounces press and release and emits one pulse
//   per accepted key.
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous, active-low reset
//     rows      in   raw keypad rows, active-high, asynchronous to clk
//     cols      out  one-hot column drive
//     key_valid out  one-cycle pulse when a debounced key is accepted
//     key_code  out  hex code of the last accepted key
//     key_held  out  high from accept until the release is debounced
module lab3_keypad_scanner
    import lab3_keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int DEBOUNCE_CYC = 400_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    scan_state_t      state;
    logic [3:0]       rows_meta;
    logic [3:0]       rows_s;
    logic [1:0]       col_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       cand_row;
    logic             rows_onehot;
    logic             dwell_end;
    logic             cand_bit;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_done;

    // Two-flop synchroniser; nothing downstream ever looks at raw rows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_meta <= '0;
            rows_s    <= '0;
        end else begin
            rows_meta <= rows;
            rows_s    <= rows_meta;
        end
    end

    assign rows_onehot = (rows_s != 4'b0000) && ((rows_s & (rows_s - 4'd1)) == 4'b0000);
    assign dwell_end   = (div_cnt == DIV_LAST);
    assign cand_bit    = ((rows_s & cand_row) != 4'b0000);
    assign cols        = 4'b0001 << col_idx;

    // The one counter serves both debounce phases; it is zeroed on the way
    // into each phase and advanced only while the sampled rows stay as
    // expected for that phase.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            SCAN:        cnt_clear = dwell_end && rows_onehot;
            DEB_PRESS:   cnt_inc   = (rows_s == cand_row);
            HELD:        cnt_clear = !cand_bit;
            DEB_RELEASE: cnt_inc   = !cand_bit;
            default:     cnt_clear = 1'b1;
        endcase
    end

    lab3_stable_counter #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_stable_counter (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .done (cnt_done)
    );

    // Scanner FSM. The column index stays frozen outside SCAN, so the
    // candidate column is simply the current col_idx. In HELD only the
    // candidate row bit is watched, which makes other keys invisible.
    // Leaving a debounce phase always resumes at the following column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col_idx   <= '0;
            div_cnt   <= '0;
            cand_row  <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell_end) begin
                        div_cnt <= '0;
                        if (rows_onehot) begin
                            cand_row <= rows_s;
                            state    <= DEB_PRESS;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (rows_s != cand_row) begin
                        state   <= SCAN;
                        col_idx <= col_idx + 2'd1;
                    end else if (cnt_done) begin
                        state     <= HELD;
                        key_valid <= 1'b1;
                        key_code  <= keymap(col_idx, cand_row);
                        key_held  <= 1'b1;
                    end
                end
                HELD: begin
                    if (!cand_bit) begin
                        state <= DEB_RELEASE;
                    end
                end
                DEB_RELEASE: begin
                    if (cand_bit) begin
                        state <= HELD;
                    end else if (cnt_done) begin
                        state    <= SCAN;
                        key_held <= 1'b0;
                        col_idx  <= col_idx + 2'd1;
                    end
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule
